// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use interlock, branch flush and multi-cycle memory stall.
// Forwarding and pipeline controls are combinational; a memory access holds F/D/E/M for MEM_LAT cycles.
module hazard_ctrl #(
    parameter int         REG_AW    = 5,
    parameter int         MEM_LAT   = 2,
    parameter logic [1:0] LOAD_CODE = 2'b01,
    parameter int         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic [1:0]        resultsrc_e,
    input  logic              pcsrc_e,
    input  logic              memreq_m,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              pc_redirect,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam int            CW      = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam bit            HAS_LAT = (MEM_LAT > 0);
    localparam logic [CW-1:0] LAT_M1  = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mem_stall;
    logic          lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (regwrite_m && rd_m != '0 && rd_m == rs)      return 2'b10;
        else if (regwrite_w && rd_w != '0 && rd_w == rs) return 2'b01;
        else                                             return 2'b00;
    endfunction

    assign forward_ae = fwd_sel(rs1_e);
    assign forward_be = fwd_sel(rs2_e);

    assign lw_stall = (resultsrc_e == LOAD_CODE) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // DONE ignores memreq_m: it is still the access that just finished waiting.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (memreq_m && HAS_LAT) begin
                    mem_stall = 1'b1;
                    cnt_nxt   = LAT_M1;
                    state_nxt = (MEM_LAT == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_nxt   = cnt - ONE;
                if (cnt == ONE) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_busy = mem_stall;

    // A held E stage cannot resolve its branch, so the redirect waits for the stall to clear.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        pc_redirect = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            pc_redirect = pcsrc_e;
            flush_d     = pcsrc_e;
            flush_e     = pcsrc_e | lw_stall;
            stall_f     = lw_stall & ~pcsrc_e;
            stall_d     = lw_stall & ~pcsrc_e;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_f && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (flush_e && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MEM_LAT=3, MEM_LAT=0 with 2-bit counters, MEM_LAT=1) share stimulus.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
    logic       regwrite_m = 1'b0, regwrite_w = 1'b0, pcsrc_e = 1'b0, memreq_m = 1'b0;
    logic [1:0] resultsrc_e = '0;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
    logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_pr, a_busy;
    logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_pr, b_busy;
    logic        c_sf, c_sd, c_se, c_sm, c_fd, c_fe, c_fw, c_pr, c_busy;
    logic [15:0] a_sc, a_fc, c_sc, c_fc;
    logic [1:0]  b_sc, b_fc;
    logic [7:0]  a_ctl;

    int n_chk  = 0;
    int n_pass = 0;

    assign a_ctl = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_pr};

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(3)) u_a (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .memreq_m(memreq_m),
        .forward_ae(a_fa), .forward_be(a_fb), .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se),
        .stall_m(a_sm), .flush_d(a_fd), .flush_e(a_fe), .flush_w(a_fw), .pc_redirect(a_pr),
        .mem_busy(a_busy), .stall_count(a_sc), .flush_count(a_fc));

    hazard_ctrl #(.MEM_LAT(0), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .memreq_m(memreq_m),
        .forward_ae(b_fa), .forward_be(b_fb), .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se),
        .stall_m(b_sm), .flush_d(b_fd), .flush_e(b_fe), .flush_w(b_fw), .pc_redirect(b_pr),
        .mem_busy(b_busy), .stall_count(b_sc), .flush_count(b_fc));

    hazard_ctrl #(.MEM_LAT(1)) u_c (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e), .memreq_m(memreq_m),
        .forward_ae(c_fa), .forward_be(c_fb), .stall_f(c_sf), .stall_d(c_sd), .stall_e(c_se),
        .stall_m(c_sm), .flush_d(c_fd), .flush_e(c_fe), .flush_w(c_fw), .pc_redirect(c_pr),
        .mem_busy(c_busy), .stall_count(c_sc), .flush_count(c_fc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] pat_a;
        logic [6:0] pat_c;
        pat_a = 7'b1110111;
        pat_c = 7'b1010101;

        // Reset state with all inputs low
        tick();
        chk("rst_ctl", {24'd0, a_ctl}, 32'd0);
        chk("rst_fwd", {28'd0, a_fa, a_fb}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_cnt", {a_sc, a_fc}, 32'd0);
        rst = 1'b1;
        tick();
        chk("idle_ctl", {24'd0, a_ctl}, 32'd0);

        // Forwarding: M beats W, then W, then x0 never forwards
        rs1_e = 5'd5; rs2_e = 5'd5; rd_m = 5'd5; rd_w = 5'd5; regwrite_m = 1'b1; regwrite_w = 1'b1;
        #1 chk("fwd_m", {28'd0, a_fa, a_fb}, {28'd0, 2'b10, 2'b10});
        regwrite_m = 1'b0;
        #1 chk("fwd_w", {28'd0, a_fa, a_fb}, {28'd0, 2'b01, 2'b01});
        regwrite_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0;
        #1 chk("fwd_x0", {28'd0, a_fa, a_fb}, 32'd0);
        rs2_e = 5'd3; rd_m = 5'd5; rd_w = 5'd3;
        #1 chk("fwd_split", {28'd0, a_fa, a_fb}, {28'd0, 2'b10, 2'b01});
        rs1_e = '0; rs2_e = '0; rd_m = '0; rd_w = '0; regwrite_m = 1'b0; regwrite_w = 1'b0;

        // Load-use interlock and its qualifiers
        resultsrc_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        #1 chk("lw_ctl", {24'd0, a_ctl}, 32'b1100_0100);
        tick();
        chk("lw_cnt", {a_sc, a_fc}, {16'd1, 16'd1});
        pcsrc_e = 1'b1;
        #1 chk("lw_br_ctl", {24'd0, a_ctl}, 32'b0000_1101);
        tick();
        chk("lw_br_cnt", {a_sc, a_fc}, {16'd1, 16'd2});
        pcsrc_e = 1'b0; resultsrc_e = 2'b00;
        #1 chk("nonload_ctl", {24'd0, a_ctl}, 32'd0);
        resultsrc_e = 2'b01; rd_e = 5'd0; rs2_d = 5'd0;
        #1 chk("lw_x0_ctl", {24'd0, a_ctl}, 32'd0);
        resultsrc_e = 2'b00;

        // Back-to-back memory accesses: A stalls 3 on/1 off, C 1 on/1 off, B never
        pulse_reset();
        memreq_m = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("busy_a_%0d", i), {31'd0, a_busy}, {31'd0, pat_a[6-i]});
            chk($sformatf("busy_c_%0d", i), {31'd0, c_busy}, {31'd0, pat_c[6-i]});
            chk($sformatf("busy_b_%0d", i), {31'd0, b_busy}, 32'd0);
            if (i == 1) chk("memstall_ctl", {24'd0, a_ctl}, 32'b1111_0010);
            tick();
        end
        chk("mem_sc_a", {16'd0, a_sc}, 32'd6);
        chk("mem_sc_c", {16'd0, c_sc}, 32'd4);
        chk("mem_sc_b", {30'd0, b_sc}, 32'd0);
        #1 chk("mem_done_busy", {31'd0, a_busy}, 32'd0);
        memreq_m = 1'b0;
        tick();

        // Branch deferred across the stall, released in DONE
        pulse_reset();
        memreq_m = 1'b1; pcsrc_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("br_hold_%0d", i), {24'd0, a_ctl}, 32'b1111_0010);
            tick();
        end
        #1 chk("br_done_ctl", {24'd0, a_ctl}, 32'b0000_1101);
        tick();
        memreq_m = 1'b0; pcsrc_e = 1'b0;
        tick();

        // Asynchronous reset in the second WAIT cycle
        pulse_reset();
        memreq_m = 1'b1;
        tick();
        tick();
        #1 chk("wait2_busy", {31'd0, a_busy}, 32'd1);
        rst = 1'b0; memreq_m = 1'b0;
        #1;
        chk("arst_ctl", {24'd0, a_ctl}, 32'd0);
        chk("arst_busy", {31'd0, a_busy}, 32'd0);
        chk("arst_cnt", {a_sc, a_fc}, 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", {23'd0, a_busy, a_ctl}, 32'd0);
        tick();
        chk("post_rst_idle2", {a_sc, 15'd0, a_busy}, 32'd0);
        memreq_m = 1'b1;
        #1 chk("first_edge_busy", {31'd0, a_busy}, 32'd1);
        tick();
        chk("first_edge_cnt", {16'd0, a_sc}, 32'd1);
        memreq_m = 1'b0;
        tick();
        tick();
        tick();

        // Counter saturation in the 2-bit instance
        pulse_reset();
        resultsrc_e = 2'b01; rd_e = 5'd9; rs1_d = 5'd9;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_sc_b", {30'd0, b_sc}, 32'd3);
        chk("sat_fc_b", {30'd0, b_fc}, 32'd3);
        chk("sat_sc_a", {16'd0, a_sc}, 32'd5);
        resultsrc_e = 2'b00; rd_e = '0; rs1_d = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
